nw_cell_scorer: RTL

Pipelined, parametrised Needleman-Wunsch cell scorer for the score-matrix fill datapath. Each accepted beat carries the three neighbour scores of one matrix cell and the match/mismatch bit. The block returns the cell's maximum score and traceback arrow two cycles later over a valid/ready handshake. It also maintains a cell counter and a sticky saturation flag, and optionally (build-time) supports Smith-Waterman local scoring.

---
 rtl/nw_cell_scorer_if.sv | 27 ++
 rtl/nw_cell_scorer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/nw_cell_scorer_if.sv
// Beat/result handshake bundle for nw_cell_scorer.
// The scorer uses the slave side; the feeder and consumer use the master side.
interface nw_cell_scorer_if #(
    parameter int W = 9
);
    logic                in_valid;
    logic                in_ready;
    logic                match;
    logic signed [W-1:0] diag;
    logic signed [W-1:0] up;
    logic signed [W-1:0] lx;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] max;
    logic [2:0]          symbol;
    logic                calc;

    modport master (
        output in_valid, match, diag, up, lx, out_ready,
        input  in_ready, out_valid, max, symbol, calc
    );

    modport slave (
        input  in_valid, match, diag, up, lx, out_ready,
        output in_ready, out_valid, max, symbol, calc
    );
endinterface

// File: rtl/nw_cell_scorer.sv
// Two-stage Needleman-Wunsch cell scorer with a cell counter and a sticky saturation flag.
// Optional macro NW_LOCAL_EN enables Smith-Waterman local scoring with a running best score.
module nw_cell_scorer #(
    parameter int          W          = 9,
    parameter int          GAP        = -2,
    parameter int          MATCH      = 1,
    parameter int          MISMATCH   = -1,
    parameter logic [2:0]  ARROW_LX   = 3'b100,
    parameter logic [2:0]  ARROW_UP   = 3'b010,
    parameter logic [2:0]  ARROW_DIAG = 3'b001,
    parameter int          CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    nw_cell_scorer_if.slave     bus,
    output logic [CNT_W-1:0]    cells,
    output logic                sat,
    output logic signed [W-1:0] best
);
    localparam int                  SENT_I     = 2**(W-1) - 1;
    localparam logic signed [W-1:0] SENT       = W'(SENT_I);
    localparam logic signed [W-1:0] ZERO       = '0;
    localparam logic signed [W:0]   C_HI       = (W+1)'(SENT_I - 1);
    localparam logic signed [W:0]   C_LO       = (W+1)'(-(2**(W-1)));
    localparam logic signed [W:0]   GAP_E      = (W+1)'(GAP);
    localparam logic signed [W:0]   MATCH_E    = (W+1)'(MATCH);
    localparam logic signed [W:0]   MISMATCH_E = (W+1)'(MISMATCH);

    function automatic logic signed [W-1:0] f_sat(input logic signed [W:0] v);
        if (v > C_HI)      f_sat = C_HI[W-1:0];
        else if (v < C_LO) f_sat = C_LO[W-1:0];
        else               f_sat = v[W-1:0];
    endfunction

    function automatic logic f_clamped(input logic signed [W:0] v);
        f_clamped = (v > C_HI) || (v < C_LO);
    endfunction

    // Ordering by candidate score, then by raw predecessor; ties favour the first argument.
    function automatic logic f_ge(input logic signed [W-1:0] c_a, input logic signed [W-1:0] r_a,
                                  input logic signed [W-1:0] c_b, input logic signed [W-1:0] r_b);
        f_ge = (c_a > c_b) || ((c_a == c_b) && (r_a >= r_b));
    endfunction

    logic                r_s1_valid;
    logic                r_s1_sent;
    logic                r_s1_clamp;
    logic signed [W-1:0] r_dc, r_uc, r_lc;
    logic signed [W-1:0] r_rd, r_ru, r_rl;

    logic                r_out_valid;
    logic signed [W-1:0] r_max;
    logic [2:0]          r_symbol;
    logic                r_calc;
    logic                r_out_clamp;

    logic [CNT_W-1:0]    r_cells;
    logic                r_sat;

    logic                w_in_ready;
    logic                w_in_fire;
    logic                w_s2_load;
    logic                w_out_fire;
    logic                w_sent;
    logic signed [W:0]   w_dc_raw, w_uc_raw, w_lc_raw;
    logic                w_diag_wins, w_up_wins;
    logic signed [W-1:0] w_win_score;
    logic [2:0]          w_win_sym;
    logic signed [W-1:0] w_max;
    logic [2:0]          w_symbol;
    logic                w_calc;

    assign w_in_ready = rst && (!r_s1_valid || !r_out_valid || bus.out_ready);
    assign w_in_fire  = bus.in_valid && w_in_ready;
    assign w_s2_load  = r_s1_valid && (!r_out_valid || bus.out_ready);
    assign w_out_fire = r_out_valid && bus.out_ready;

    assign w_sent   = (bus.diag == SENT) || (bus.up == SENT) || (bus.lx == SENT);
    assign w_dc_raw = $signed({bus.diag[W-1], bus.diag}) + (bus.match ? MATCH_E : MISMATCH_E);
    assign w_uc_raw = $signed({bus.up[W-1], bus.up}) + GAP_E;
    assign w_lc_raw = $signed({bus.lx[W-1], bus.lx}) + GAP_E;

    always_comb begin
        w_diag_wins = f_ge(r_dc, r_rd, r_uc, r_ru) && f_ge(r_dc, r_rd, r_lc, r_rl);
        w_up_wins   = !w_diag_wins && f_ge(r_uc, r_ru, r_lc, r_rl);
        w_win_score = r_lc;
        w_win_sym   = ARROW_LX;
        if (w_diag_wins) begin
            w_win_score = r_dc;
            w_win_sym   = ARROW_DIAG;
        end else if (w_up_wins) begin
            w_win_score = r_uc;
            w_win_sym   = ARROW_UP;
        end

        w_max    = w_win_score;
        w_symbol = w_win_sym;
        w_calc   = 1'b1;
`ifdef NW_LOCAL_EN
        // The implicit zero candidate wins whenever nothing scores above it.
        if (w_win_score <= ZERO) begin
            w_max    = ZERO;
            w_symbol = 3'b000;
        end
`endif
        if (r_s1_sent) begin
            w_max    = SENT;
            w_symbol = 3'b000;
            w_calc   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_sent   <= 1'b0;
            r_s1_clamp  <= 1'b0;
            r_dc        <= ZERO;
            r_uc        <= ZERO;
            r_lc        <= ZERO;
            r_rd        <= ZERO;
            r_ru        <= ZERO;
            r_rl        <= ZERO;
            r_out_valid <= 1'b0;
            r_max       <= SENT;
            r_symbol    <= 3'b000;
            r_calc      <= 1'b0;
            r_out_clamp <= 1'b0;
        end else begin
            if (w_in_fire) begin
                r_s1_valid <= 1'b1;
                r_s1_sent  <= w_sent;
                r_s1_clamp <= !w_sent && (f_clamped(w_dc_raw) || f_clamped(w_uc_raw) ||
                                          f_clamped(w_lc_raw));
                r_dc       <= f_sat(w_dc_raw);
                r_uc       <= f_sat(w_uc_raw);
                r_lc       <= f_sat(w_lc_raw);
                r_rd       <= bus.diag;
                r_ru       <= bus.up;
                r_rl       <= bus.lx;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end

            if (w_s2_load) begin
                r_out_valid <= 1'b1;
                r_max       <= w_max;
                r_symbol    <= w_symbol;
                r_calc      <= w_calc;
                r_out_clamp <= r_s1_clamp;
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            r_cells <= '0;
            r_sat   <= 1'b0;
        end else if (w_out_fire && r_calc) begin
            r_cells <= r_cells + CNT_W'(1);
            if (r_out_clamp) r_sat <= 1'b1;
        end
    end

`ifdef NW_LOCAL_EN
    logic signed [W-1:0] r_best;

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            r_best <= ZERO;
        end else if (w_out_fire && r_calc && (r_max > r_best)) begin
            r_best <= r_max;
        end
    end

    assign best = r_best;
`else
    assign best = ZERO;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.max       = r_max;
    assign bus.symbol    = r_symbol;
    assign bus.calc      = r_calc;
    assign cells         = r_cells;
    assign sat           = r_sat;
endmodule
